// File: rtl/nn_argmax_classifier_pkg.sv
// Shared constants and types for the argmax classifier stage.
//   NN_NUM_CLASSES : beats per frame
//   NN_SCORE_W     : signed score width
//   NN_IDX_W       : class index width
//   NN_NO_RESULT   : class_out value meaning "no result yet"
//   nn_state_e     : frame FSM states
package nn_pkg;

  localparam int unsigned NN_NUM_CLASSES = 10;
  localparam int unsigned NN_SCORE_W     = 16;
  localparam int unsigned NN_IDX_W       = 4;

  localparam logic [NN_IDX_W-1:0] NN_NO_RESULT = '1;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StDone
  } nn_state_e;

endpackage

// File: rtl/nn_argmax_classifier_if.sv
// Score stream between the output layer and the argmax stage.
//   score_valid : beat valid (upstream)
//   score_ready : stage can accept a beat (downstream)
//   score_data  : signed class score (upstream)
//   score_last  : final beat of a frame (upstream)
// Modports: master = upstream producer, slave = argmax stage.
interface nn_argmax_classifier_if #(
  parameter int unsigned DATA_W = nn_pkg::NN_SCORE_W
);

  logic              score_valid;
  logic              score_ready;
  logic [DATA_W-1:0] score_data;
  logic              score_last;

  modport master (
    output score_valid,
    output score_data,
    output score_last,
    input  score_ready
  );

  modport slave (
    input  score_valid,
    input  score_data,
    input  score_last,
    output score_ready
  );

endinterface

// File: rtl/nn_argmax_classifier_score_cmp.sv
// Running-maximum tracker for one frame.
//   clk, reset_n : clock, async active-low reset
//   load         : first beat of a frame; loads data unconditionally, index 0
//   update       : later beat; replaces the best only if data > best (signed)
//   data         : incoming score
//   idx          : index of the incoming beat
//   best_idx     : index of the current best score
module nn_score_cmp #(
  parameter int unsigned DATA_W = nn_pkg::NN_SCORE_W,
  parameter int unsigned IDX_W  = nn_pkg::NN_IDX_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic                     update,
  input  logic signed [DATA_W-1:0] data,
  input  logic        [IDX_W-1:0]  idx,
  output logic        [IDX_W-1:0]  best_idx
);

  logic signed [DATA_W-1:0] best_val_q;
  logic        [IDX_W-1:0]  best_idx_q;
  logic                     greater;

  // Strict compare: on a tie the earlier (lower) index is kept.
  assign greater  = data > best_val_q;
  assign best_idx = best_idx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      best_val_q <= {1'b1, {(DATA_W-1){1'b0}}};
      best_idx_q <= '0;
    end else if (load) begin
      best_val_q <= data;
      best_idx_q <= '0;
    end else if (update && greater) begin
      best_val_q <= data;
      best_idx_q <= idx;
    end
  end

endmodule

// File: rtl/nn_argmax_classifier.sv
// Streaming argmax stage feeding the HPS-readable 4-bit PIO.
//   clk, reset_n : clock, async active-low reset
//   clear        : sync abort of the frame in progress; also clears err
//   score        : score stream (slave modport)
//   class_out    : held winning index; all-ones until the first commit
//   result_valid : one-cycle pulse when class_out updates
//   busy         : a frame is in progress (Acc or Done)
//   err          : sticky frame-length error
// IDX_W must satisfy 2**IDX_W > NUM_CLASSES so the sentinel stays unused.
module nn_argmax_classifier
  import nn_pkg::*;
#(
  parameter int unsigned DATA_W      = NN_SCORE_W,
  parameter int unsigned NUM_CLASSES = NN_NUM_CLASSES,
  parameter int unsigned IDX_W       = NN_IDX_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  nn_argmax_classifier_if.slave  score,
  output logic [IDX_W-1:0]       class_out,
  output logic                   result_valid,
  output logic                   busy,
  output logic                   err
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);

  nn_state_e        state_q;
  logic [IDX_W-1:0] count_q;
  logic [IDX_W-1:0] class_q;
  logic             result_valid_q;
  logic             err_q;
  logic [IDX_W-1:0] best_idx;
  logic             accept;

  assign score.score_ready = (state_q != StDone);
  assign busy              = (state_q != StIdle);
  assign class_out         = class_q;
  assign result_valid      = result_valid_q;
  assign err               = err_q;

  // A beat coinciding with clear is dropped.
  assign accept = score.score_valid && score.score_ready && !clear;

  nn_score_cmp #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_score_cmp (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept && (state_q == StIdle)),
    .update   (accept && (state_q == StAcc)),
    .data     (score.score_data),
    .idx      (count_q),
    .best_idx (best_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      count_q        <= '0;
      class_q        <= '1;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else if (clear) begin
      // class_q deliberately kept so the last good result stays visible.
      state_q        <= StIdle;
      count_q        <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            count_q <= IDX_W'(1);
            if (score.score_last) begin
              state_q <= StDone;
              err_q   <= 1'b1;
            end else begin
              state_q <= StAcc;
            end
          end
        end
        StAcc: begin
          if (accept) begin
            count_q <= count_q + IDX_W'(1);
            if (score.score_last || (count_q == LastIdx)) begin
              state_q <= StDone;
              // Short frame (early last) or truncated frame (missing last).
              if (score.score_last != (count_q == LastIdx)) begin
                err_q <= 1'b1;
              end
            end
          end
        end
        StDone: begin
          class_q        <= best_idx;
          result_valid_q <= 1'b1;
          count_q        <= '0;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_argmax_classifier.sv
// Directed self-checking bench for nn_argmax_classifier.
module tb_nn_argmax_classifier;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic [3:0] class_out;
  logic       result_valid;
  logic       busy;
  logic       err;

  int n_checks;
  int n_errors;
  int acc_beats;
  int fr[$];

  nn_argmax_classifier_if #(.DATA_W(16)) sif ();

  nn_argmax_classifier #(
    .DATA_W      (16),
    .NUM_CLASSES (10),
    .IDX_W       (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .score        (sif.slave),
    .class_out    (class_out),
    .result_valid (result_valid),
    .busy         (busy),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent count of accepted beats.
  always @(posedge clk) begin
    if (reset_n && !clear && sif.score_valid && sif.score_ready) acc_beats <= acc_beats + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input int d, input bit l);
    int guard;
    guard = 0;
    sif.score_valid = 1'b1;
    sif.score_data  = 16'(d);
    sif.score_last  = l;
    while (!sif.score_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check_eq("ready_timeout", 32'(sif.score_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    sif.score_valid = 1'b0;
    sif.score_last  = 1'b0;
  endtask

  task automatic send_frame(input bit with_last, input bit gaps);
    for (int i = 0; i < fr.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(fr[i], with_last && (i == fr.size() - 1));
    end
  endtask

  // Starts at the negedge right after the final accept.
  task automatic finish_frame(input string tag, input int exp_cls, input bit exp_err);
    check_eq({tag, "_ready_done"}, 32'(sif.score_ready), 32'd0);
    check_eq({tag, "_busy_done"}, 32'(busy), 32'd1);
    check_eq({tag, "_rv_early"}, 32'(result_valid), 32'd0);
    @(negedge clk);
    check_eq({tag, "_rv"}, 32'(result_valid), 32'd1);
    check_eq({tag, "_class"}, 32'(class_out), 32'(exp_cls));
    check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
    check_eq({tag, "_ready_back"}, 32'(sif.score_ready), 32'd1);
    @(negedge clk);
    check_eq({tag, "_rv_drop"}, 32'(result_valid), 32'd0);
    check_eq({tag, "_class_hold"}, 32'(class_out), 32'(exp_cls));
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int snap;
    n_checks        = 0;
    n_errors        = 0;
    acc_beats       = 0;
    reset_n         = 1'b0;
    clear           = 1'b0;
    sif.score_valid = 1'b0;
    sif.score_data  = '0;
    sif.score_last  = 1'b0;
    #12;
    check_eq("rst_class", 32'(class_out), 32'hF);
    check_eq("rst_rv", 32'(result_valid), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_ready", 32'(sif.score_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Nominal frame, valid held high; tie at index 4 must not win.
    fr = '{3, -7, 12, 0, 12, 5, -1, 9, 2, 11};
    send_frame(1'b1, 1'b0);
    finish_frame("nominal", 2, 1'b0);

    // All most-negative: first beat loads, lowest index wins.
    fr = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    send_frame(1'b1, 1'b0);
    finish_frame("ties", 0, 1'b0);

    // Short frame sets sticky err.
    fr = '{1, 2, 9, 3, 4};
    send_frame(1'b1, 1'b0);
    finish_frame("short", 2, 1'b1);

    // Good frame keeps err set.
    fr = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
    send_frame(1'b1, 1'b0);
    finish_frame("sticky", 8, 1'b1);
    pulse_clear();
    check_eq("clr_err", 32'(err), 32'd0);
    check_eq("clr_class", 32'(class_out), 32'd8);

    // Gaps in valid; beat count must be exact.
    snap = acc_beats;
    fr = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 100};
    send_frame(1'b1, 1'b1);
    finish_frame("gaps", 9, 1'b0);
    check_eq("gaps_beats", 32'(acc_beats - snap), 32'd10);

    // Missing last: truncated at ten beats with err.
    fr = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
    send_frame(1'b0, 1'b0);
    finish_frame("trunc", 0, 1'b1);
    pulse_clear();

    // Commit 7, then abort a frame mid-way.
    fr = '{0, 0, 0, 0, 0, 0, 0, 50, 0, 0};
    send_frame(1'b1, 1'b0);
    finish_frame("pre_clr", 7, 1'b0);
    fr = '{90, 91, 92, 93};
    send_frame(1'b0, 1'b0);
    snap = acc_beats;
    sif.score_valid = 1'b1;
    sif.score_data  = 16'd99;
    pulse_clear();
    sif.score_valid = 1'b0;
    check_eq("abort_class", 32'(class_out), 32'd7);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_rv", 32'(result_valid), 32'd0);
    check_eq("abort_drop", 32'(acc_beats - snap), 32'd0);
    fr = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 5};
    send_frame(1'b1, 1'b0);
    finish_frame("post_clr", 8, 1'b0);

    // Asynchronous reset mid-frame.
    fr = '{1, 2, 3};
    send_frame(1'b0, 1'b0);
    check_eq("mid_busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_class", 32'(class_out), 32'hF);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_ready", 32'(sif.score_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nn_argmax_classifier.md
Name: nn_argmax_classifier

Overview:
- Streaming argmax stage that sits directly upstream of the 4-bit HPS-readable output PIO.
- Consumes the per-class signed scores from the network's output layer, one beat per class, over a valid/ready stream.
- Reduces each frame to a 4-bit winning class index and holds it on `class_out` until the next frame commits, so the HPS can sample it at any time.
- Also provides a one-cycle commit pulse and a sticky frame-error flag.

Parameters:
- DATA_W, 16: width of each signed two's-complement score.
- NUM_CLASSES, 10: expected number of beats per frame; legal range 2..15.
- IDX_W, 4: width of the class index; must satisfy 2^IDX_W > NUM_CLASSES.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset
- clear  input  1  synchronous abort of the frame in progress; also clears err
- score_valid  input  1  score beat valid
- score_ready  output  1  stage can accept a beat
- score_data  input  DATA_W  signed class score
- score_last  input  1  marks the final beat of a frame
- class_out  output  IDX_W  held winning index; drives the PIO in_port
- result_valid  output  1  one-cycle pulse when class_out updates
- busy  output  1  a frame is in progress (state ACC or DONE)
- err  output  1  sticky frame-length error

Behaviour:
- Reset reset_n is asynchronous, active-low; clock clk. All state is on the rising edge of clk.
- Reset values:
  - state = IDLE
  - class_out = all-ones (4'hF, the "no result" sentinel)
  - result_valid = 0
  - err = 0
  - score_ready = 1
  - busy = 0
  - internal count = 0, best_idx = 0, best_val = most-negative value
- Beat acceptance: a beat is accepted on an edge where score_valid && score_ready. The upstream holds data stable while valid && !ready.
- States:
  - IDLE: score_ready=1. On accept: best_val <= data, best_idx <= 0, count <= 1. If score_last is set, go to DONE and set err (frame too short); otherwise go to ACC.
  - ACC: score_ready=1. On accept: if data > best_val (strictly greater, signed), then best_val <= data and best_idx <= count. In all cases count <= count+1.
    - If score_last && count == NUM_CLASSES-1: go to DONE.
    - If score_last && count < NUM_CLASSES-1: go to DONE and set err.
    - If !score_last && count == NUM_CLASSES-1: go to DONE and set err. Frame is truncated; surplus beats are treated as a new frame.
  - DONE: score_ready=0, lasts exactly one cycle. At the edge leaving DONE: class_out <= best_idx, result_valid <= 1, state <= IDLE.
- Timing: result_valid is high for the single cycle after DONE. class_out is therefore updated 2 edges after the final beat is accepted.
- Throughput: maximum NUM_CLASSES beats per NUM_CLASSES+1 cycles, because of the one DONE bubble.
- Ties: the lowest index wins, since comparison is strictly greater.
- Extreme values: a score equal to the most-negative value is valid. The first beat always loads best_val, independent of the comparison.
- err: sticky; it is set in the same edge as the transition to DONE. It is cleared only by reset or by clear.
- clear:
  - In any state, forces IDLE, count=0, err=0, result_valid=0.
  - class_out is NOT changed; the last good result stays visible.
  - A beat presented in the same cycle as clear is dropped.
  - clear has priority over score acceptance and over the DONE commit.
- Reset mid-frame: all state returns to reset values, including class_out = 4'hF.
- When NUM_CLASSES is less than 2^IDX_W - 1, class_out never equals 4'hF after a valid commit. Software uses 4'hF to mean "no result yet".

Decomposition:
- Shared package nn_pkg holds:
  - constants NN_NUM_CLASSES=10, NN_SCORE_W=16, NN_IDX_W=4, NN_NO_RESULT='1
  - the state enum {IDLE, ACC, DONE}
- One natural sub-module, nn_score_cmp: registered best_val/best_idx tracker with load/update enables and a signed strictly-greater compare.
- The FSM, counter and output registers stay in the top level.

Test Plan:
- Reset only: class_out=4'hF, result_valid=0, err=0, score_ready=1, busy=0.
- Frame {3,-7,12,0,12,5,-1,9,2,11} with last on beat 9, valid held high: class_out=2 two edges after the last accept; result_valid pulses for exactly 1 cycle; err=0; score_ready=0 for exactly one cycle (DONE).
- All-equal frame of ten beats of -32768: class_out=0 (lowest index wins ties); err=0.
- Short frame: 5 beats {1,2,9,3,4} with last on beat 4: class_out=2, err=1; err stays 1 through a following good frame until clear is pulsed.
- Back-pressure and gaps: random score_valid deasserts within the frame {0,0,0,0,0,0,0,0,0,100}: class_out=9; no beat is lost or duplicated (scoreboard beat count = 10).
- Assert clear after 4 beats of a frame whose earlier committed result was 7: class_out stays 7; the next full frame commits normally; asserting reset_n low mid-frame gives class_out=4'hF asynchronously.
